// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// A fetch entry pairs an instruction word with the address it came from.
package fetch_pkg;

  localparam int ADDR_W  = 11;
  localparam int INSTR_W = 14;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_st_t;

  // Sequential program address; wraps naturally at 2^ADDR_W.
  function automatic logic [ADDR_W-1:0] pc_next(input logic [ADDR_W-1:0] pc);
    return pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_if.sv
// ROM bus plus instruction delivery handshake of the fetch stage.
// The master side is the fetch unit; the slave side is the ROM/consumer.
interface instr_fetch_unit_if;
  import fetch_pkg::*;

  logic               rom_req;
  logic [ADDR_W-1:0]  rom_addr;
  logic [INSTR_W-1:0] rom_data;

  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready;

  modport master (
    output rom_req,
    output rom_addr,
    input  rom_data,
    output instr,
    output instr_pc,
    output instr_valid,
    input  instr_ready
  );

  modport slave (
    input  rom_req,
    input  rom_addr,
    output rom_data,
    input  instr,
    input  instr_pc,
    input  instr_valid,
    output instr_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch entries used as the prefetch buffer.
// Flush empties the buffer and wins over any push or pop in the same cycle.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       flush,
  input  fetch_entry_t               push_data,
  output fetch_entry_t               head,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // A push into a full buffer is only legal when the head leaves the same cycle.
  always_comb begin
    do_push = push && (!full || pop);
    do_pop  = pop && !empty;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    head  = mem[rd_ptr];
    empty = (count == '0);
    full  = (count == CNT_MAX);
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: sequences the PC into the program ROM, tracks the single
// outstanding read and buffers returned words for the downstream controller.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              busy,
  instr_fetch_unit_if.master bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(DEPTH);

  fetch_st_t         st;
  logic [ADDR_W-1:0] pc_q;
  logic [ADDR_W-1:0] inflight_pc;
  logic              inflight_q;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  fetch_entry_t      fifo_head;
  fetch_entry_t      push_entry;
  fetch_entry_t      shown_q;

  logic [CNT_W:0]    credit_used;
  logic              req;
  logic              push;
  logic              pop;
  logic              valid;

  // Buffered entries plus the outstanding read must leave room for its reply,
  // so a returning word always has a slot and is never dropped.
  always_comb begin
    credit_used = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
    req         = (st == RUN) && fetch_en && !redirect && !fifo_full
                  && (credit_used < CREDIT_MAX);
    push        = inflight_q && !redirect;
    valid       = !fifo_empty && !redirect;
    pop         = valid && bus.instr_ready;
    push_entry  = '{pc: inflight_pc, instr: bus.rom_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st          <= IDLE;
      pc_q        <= '0;
      inflight_q  <= 1'b0;
      inflight_pc <= '0;
    end else if (redirect) begin
      st          <= fetch_en ? RUN : IDLE;
      pc_q        <= redirect_pc;
      inflight_q  <= 1'b0;
    end else begin
      case (st)
        IDLE:    if (fetch_en)  st <= RUN;
        RUN:     if (!fetch_en) st <= IDLE;
        default: st <= IDLE;
      endcase
      inflight_q <= req;
      if (req) begin
        pc_q        <= pc_next(pc_q);
        inflight_pc <= pc_q;
      end
    end
  end

  // Remembers the last head so the outputs hold steady once the buffer drains.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shown_q <= '0;
    end else if (!fifo_empty) begin
      shown_q <= fifo_head;
    end
  end

  fetch_fifo #(
    .DEPTH     (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .flush     (redirect),
    .push_data (push_entry),
    .head      (fifo_head),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  always_comb begin
    bus.rom_req     = req;
    bus.rom_addr    = pc_q;
    bus.instr_valid = valid;
    bus.instr       = fifo_empty ? shown_q.instr : fifo_head.instr;
    bus.instr_pc    = fifo_empty ? shown_q.pc    : fifo_head.pc;
    busy            = !fifo_empty || inflight_q;
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed and randomized bench for instr_fetch_unit against a queue-based
// model of requested-but-undelivered program addresses.
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  typedef struct {
    logic [10:0] pc;
    int          cyc;
  } pend_t;

  logic        clk;
  logic        reset;
  logic        fetch_en;
  logic        redirect;
  logic [10:0] redirect_pc;
  logic        busy;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .DEPTH       (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .busy        (busy),
    .bus         (bus)
  );

  int          checks;
  int          failures;
  pend_t       pend[$];
  logic [10:0] next_addr;
  logic        prev_fe;
  int          cyc;
  logic        req_now;
  logic [10:0] last_req_pc;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [13:0] rom_word(input logic [10:0] a);
    return 14'h3000 + {3'b000, a};
  endfunction

  // Program ROM: one cycle read latency, garbage when not addressed.
  always @(posedge clk) begin
    bus.rom_data <= bus.rom_req ? rom_word(bus.rom_addr) : 14'($urandom);
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, "_instr_valid"}, bus.instr_valid, 0);
    check_output({tag, "_rom_req"}, bus.rom_req, 0);
    check_output({tag, "_busy"}, busy, 0);
    check_output({tag, "_rom_addr"}, bus.rom_addr, 0);
    check_output({tag, "_instr"}, bus.instr, 0);
    check_output({tag, "_instr_pc"}, bus.instr_pc, 0);
  endtask

  task automatic do_reset();
    reset           = 1'b0;
    fetch_en        = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    bus.instr_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset     = 1'b1;
    pend.delete();
    next_addr = '0;
    prev_fe   = 1'b0;
    cyc       = 0;
  endtask

  // One clock: drive inputs, compare outputs with the model, advance the model.
  task automatic apply_stimulus(input logic fe, input logic rdy, input logic rd,
                                input logic [10:0] rpc);
    logic exp_valid;
    logic exp_req;
    @(negedge clk);
    fetch_en        = fe;
    bus.instr_ready = rdy;
    redirect        = rd;
    redirect_pc     = rpc;
    #1;
    exp_valid = !rd && (pend.size() > 0) && (pend[0].cyc + 2 <= cyc);
    exp_req   = prev_fe && fe && !rd && (pend.size() < DEPTH);
    check_output("instr_valid", bus.instr_valid, exp_valid);
    if (exp_valid) begin
      check_output("instr_pc", bus.instr_pc, pend[0].pc);
      check_output("instr", bus.instr, rom_word(pend[0].pc));
    end
    check_output("rom_req", bus.rom_req, exp_req);
    if (exp_req) check_output("rom_addr", bus.rom_addr, next_addr);
    check_output("busy", busy, pend.size() != 0);
    req_now = exp_req;
    if (rd) begin
      pend.delete();
      next_addr = rpc;
    end else begin
      if (exp_valid && rdy) void'(pend.pop_front());
      if (exp_req) begin
        pend.push_back('{pc: next_addr, cyc: cyc});
        last_req_pc = next_addr;
        next_addr   = next_addr + 11'd1;
      end
    end
    prev_fe = fe;
    cyc++;
  endtask

  initial begin
    logic found;
    checks   = 0;
    failures = 0;
    req_now  = 1'b0;
    last_req_pc = '0;
    cyc      = 0;

    // Power-up reset state
    reset           = 1'b0;
    fetch_en        = 1'b0;
    redirect        = 1'b0;
    redirect_pc     = '0;
    bus.instr_ready = 1'b0;
    #1;
    check_reset_outputs("por");
    do_reset();
    check_reset_outputs("post_release");

    // Straight-line fetch
    $display("[TB] straight-line fetch");
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b1, 1'b0, '0);

    // Backpressure from a clean start
    $display("[TB] backpressure");
    do_reset();
    for (int i = 0; i < 10; i++) apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    check_output("bp_rom_req", bus.rom_req, 0);
    check_output("bp_valid", bus.instr_valid, 1);
    check_output("bp_head_pc", bus.instr_pc, 0);
    check_output("bp_head_instr", bus.instr, 14'h3000);
    for (int i = 0; i < 12; i++) apply_stimulus(1'b1, 1'b1, 1'b0, '0);

    // Redirect in the cycle the reply for pc 5 arrives
    $display("[TB] redirect with read in flight");
    apply_stimulus(1'b1, 1'b1, 1'b1, 11'h000);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      apply_stimulus(1'b1, 1'b1, 1'b0, '0);
      if (req_now && last_req_pc == 11'h005) found = 1'b1;
    end
    check_output("find_pc5_req", found, 1);
    apply_stimulus(1'b1, 1'b1, 1'b1, 11'h123);
    check_output("redir_valid", bus.instr_valid, 0);
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    check_output("redir_rom_req", bus.rom_req, 1);
    check_output("redir_rom_addr", bus.rom_addr, 11'h123);
    check_output("redir_busy", busy, 0);
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    check_output("redir_first_pc", bus.instr_pc, 11'h123);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 1'b0, '0);

    // Address wrap-around
    $display("[TB] wrap-around");
    apply_stimulus(1'b1, 1'b1, 1'b1, 11'h7FE);
    for (int i = 0; i < 8; i++) apply_stimulus(1'b1, 1'b1, 1'b0, '0);

    // fetch_en drop with one read in flight
    $display("[TB] fetch_en drop");
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    check_output("drop_req_before", bus.rom_req, 1);
    for (int i = 0; i < 6; i++) apply_stimulus(1'b0, 1'b1, 1'b0, '0);
    check_output("drop_rom_req", bus.rom_req, 0);
    check_output("drop_busy", busy, 0);

    // Async reset with three buffered entries
    $display("[TB] async reset mid-stream");
    apply_stimulus(1'b1, 1'b0, 1'b1, 11'h040);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b1, 1'b0, 1'b0, '0);
    for (int i = 0; i < 3; i++) apply_stimulus(1'b0, 1'b0, 1'b0, '0);
    check_output("pre_rst_valid", bus.instr_valid, 1);
    #2;
    reset = 1'b0;
    #1;
    check_output("arst_valid", bus.instr_valid, 0);
    check_output("arst_rom_req", bus.rom_req, 0);
    check_output("arst_busy", busy, 0);
    do_reset();
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    apply_stimulus(1'b1, 1'b1, 1'b0, '0);
    check_output("arst_first_req", bus.rom_req, 1);
    check_output("arst_first_addr", bus.rom_addr, 0);
    for (int i = 0; i < 4; i++) apply_stimulus(1'b1, 1'b1, 1'b0, '0);

    // Randomized traffic
    $display("[TB] randomized traffic");
    for (int i = 0; i < 600; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0,
                     $urandom_range(0, 4) < 3,
                     $urandom_range(0, 19) == 0,
                     11'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Instruction fetch stage sitting directly upstream of the execute/decode controller.
- Generates sequential program addresses into the 2K x 14 program ROM and buffers the returned instructions in a small prefetch FIFO.
- Presents instructions with their PC through a valid/ready handshake.
- Supports redirect (jump/branch) with flush, so the downstream controller no longer sequences PC, MAR and ROM itself.

Parameters:
- ADDR_W, 11, program counter / ROM address width.
- INSTR_W, 14, instruction word width.
- DEPTH, 4, prefetch FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low reset.
- fetch_en  in  1  permits new ROM requests while high.
- rom_req  out  1  ROM read request this cycle.
- rom_addr  out  ADDR_W  ROM read address; meaningful when rom_req=1.
- rom_data  in  INSTR_W  ROM read data, valid exactly 1 cycle after the matching rom_req.
- instr  out  INSTR_W  instruction at FIFO head.
- instr_pc  out  ADDR_W  address the head instruction was fetched from.
- instr_valid  out  1  head entry available.
- instr_ready  in  1  consumer accepts the head entry.
- redirect  in  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  ADDR_W  new fetch address; sampled when redirect=1.
- busy  out  1  FIFO non-empty or a request is in flight.

Behaviour:
- Reset (reset=0, async): pc_q=0, FIFO empty, inflight_q=0, st=IDLE. Outputs during and after reset: rom_req=0, rom_addr=0, instr_valid=0, instr=0, instr_pc=0, busy=0.
- FSM st:
  - IDLE -> RUN when fetch_en=1.
  - RUN -> IDLE when fetch_en=0.
  - Any state -> RUN on redirect if fetch_en=1, else -> IDLE.
  - IDLE still drains the FIFO and still accepts an in-flight response.
- Request rule (combinational): rom_req = (st==RUN) && fetch_en && !redirect && (count + inflight_q < DEPTH). rom_addr = pc_q.
  - The credit rule guarantees the FIFO can never overflow; no response is ever dropped for lack of space.
- On rom_req=1: pc_q <= pc_q+1 modulo 2^ADDR_W (2047 wraps to 0), inflight_q <= 1, inflight_pc <= pc_q. Otherwise inflight_q <= 0.
- Response: if inflight_q=1 and redirect=0, push {inflight_pc, rom_data} into the FIFO at the clock edge.
- Handshake: instr_valid = !empty && !redirect.
  - Pop when instr_valid && instr_ready.
  - instr and instr_pc are stable while instr_valid=1 and instr_ready=0.
  - When the FIFO is empty, instr and instr_pc hold their last value (0 after reset).
- Simultaneous push and pop: allowed at any occupancy including full; count unchanged.
- Latency: request in cycle n, push at end of n+1, instr_valid in n+2. Steady-state throughput is 1 instr/cycle with instr_ready held 1.
- Redirect (cycle r):
  - No request, no push (the in-flight response is discarded), no pop.
  - FIFO flushed to empty; inflight_q <= 0; pc_q <= redirect_pc.
  - First request at redirect_pc in cycle r+1 (if fetch_en=1); its instruction is valid in r+3.
- Redirect has priority over all other events in the same cycle.
- fetch_en falling: no new requests; any response already in flight is still pushed; entries remain poppable.
- reset asserted mid-operation: all state cleared immediately; any response arriving after reset release is ignored because inflight_q=0.
- busy = !empty || inflight_q.

Decomposition:
- Package fetch_pkg:
  - ADDR_W and INSTR_W constants.
  - typedef fetch_entry_t struct {pc, instr}.
  - typedef fetch_st_t enum {IDLE, RUN}.
- Sub-module fetch_fifo: DEPTH-entry synchronous FIFO of fetch_entry_t with push, pop, flush, count, empty, full. Async active-low reset; flush has priority over push and pop.
- Top level holds the FSM, PC, in-flight tracking and credit logic.

Test Plan:
- Straight-line fetch: reset release, fetch_en=1, instr_ready=1, ROM[a]=14'h3000+a -> instr_valid first high 2 cycles after the first rom_req. Then one instruction per cycle: pc 0,1,2,3 with instr 3000,3001,3002,3003.
- Backpressure: instr_ready=0 for 10 cycles -> exactly 4 entries buffered, rom_req=0 once count+inflight=4, head holds pc=0. Release -> pc 0..3 delivered in order, then fetch resumes at 4 with no gap or duplicate.
- Redirect with request in flight: redirect=1, redirect_pc=11'h123 in the cycle a response for pc=5 arrives -> response discarded, FIFO empty, next rom_addr=11'h123, next delivered instr_pc=11'h123.
- Wrap-around: redirect_pc=11'h7FE -> delivered pc sequence 7FE, 7FF, 000, 001.
- fetch_en drop: deassert fetch_en the cycle after a request -> that in-flight instruction is still delivered, rom_req stays 0, busy falls to 0 after the FIFO drains.
- Async reset mid-stream: assert reset between clock edges with 3 entries buffered -> instr_valid, rom_req and busy go 0 immediately. After release with fetch_en=1, the first rom_addr is 0.
